bitonic_loader: RTL and testbench
=================================

Name: bitonic_loader

Overview:
- Upstream stage of the bitonic sorter.
- Accepts a serial valid/ready word stream and packs up to DEPTH words into one parallel vector.
- Pads short blocks with a sentinel so the padding sorts to the tail, then presents the vector to the sorter with a one-cycle valid pulse.
- The sorter has no backpressure, so this block owns all input flow control.

Parameters:
- DEPTH, 8, words per block; power of two, >= 2.
- WIDTH, 32, bits per word.
- DIR, 1, sort direction of the downstream sorter. 1 = ascending, so the pad word is all-ones. 0 = descending, so the pad word is all-zeros.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_data / in_last are valid this cycle.
- in_data  input  WIDTH  input word.
- in_last  input  1  final word of the current block; qualified by in_valid.
- in_ready  output  1  block can accept a word this cycle.
- out_seq  output  WIDTH x DEPTH (unpacked [DEPTH-1:0])  packed block; word k = k-th accepted word.
- out_valid  output  1  one-cycle pulse; out_seq is valid.
- out_count  output  $clog2(DEPTH)+1  number of real (non-pad) words in out_seq, range 1..DEPTH.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - state = FILL, idx = 0, all buffer slots = PAD.
  - out_valid = 0, out_seq = all zeros, out_count = 0.
  - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after rst deasserts.
- Handshake: a word is accepted when in_valid && in_ready. in_data, in_last and in_valid are ignored when in_ready = 0.
- FILL state (in_ready = 1):
  - On accept: buf[idx] <= in_data, idx <= idx + 1.
  - If in_last = 1 or idx == DEPTH-1 on accept: go to ISSUE and latch count = idx + 1.
  - in_last on word DEPTH-1 is the same as a full block.
- ISSUE state (in_ready = 0), one cycle:
  - Register out_seq <= buf, out_count <= count, out_valid <= 1.
  - Reset buf to all PAD and idx to 0, then return to FILL.
  - Unfilled slots therefore hold PAD.
- out_valid and out_count:
  - out_valid is high for exactly one cycle per block.
  - When out_valid = 0, out_seq and out_count are driven to zero; the downstream stage expects zeroed data when not valid.
- Latency and throughput:
  - The final word is accepted at edge t, so ISSUE is active in cycle t..t+1 and out_valid is high in the cycle after edge t+1. That is two edges from the last accept to visible out_valid.
  - Minimum block period is DEPTH+1 cycles for full blocks and n+1 cycles for an n-word block.
  - in_ready is low only during the ISSUE cycle.
- Idle: in_valid low in FILL holds state; gaps between words are allowed, with no timeout.
- An in_last with no preceding words gives a 1-word block, out_count = 1.
- Reset mid-fill discards the partial block; no out_valid is produced for it.
- Reset in the ISSUE cycle suppresses that out_valid.
- Words are never reordered; slot k always holds the k-th accepted word of the block.
- Counters:
  - idx width is $clog2(DEPTH).
  - The last-slot compare must not rely on wrap-around.
  - count width matches out_count so a value of DEPTH is representable.

Test Plan:
1. Full block, DEPTH=8, DIR=1: words 8,7,6,5,4,3,2,1 on consecutive cycles, in_last on the 8th -> one out_valid pulse, out_seq[0..7] = 8..1, out_count = 8, in_ready low exactly one cycle.
2. Short block, DIR=1: words 5,9,2 with in_last on 2 -> out_seq = {5,9,2,FFFFFFFF x5}, out_count = 3. Repeat with DIR=0 -> pad slots = 00000000.
3. Back-to-back: two 8-word blocks with in_valid held high throughout -> exactly one stall cycle between blocks, two out_valid pulses 9 cycles apart, second block contains no words from the first.
4. Gapped input: 4 words with random 0-3 idle cycles between each, in_last on the 4th -> correct order, out_count = 4, out_valid and out_seq zero at all other times.
5. Reset mid-operation: accept 3 words, assert rst for 1 cycle, then send 2 words with in_last -> single pulse, out_seq = {w0,w1,PAD x6}, out_count = 2, no stale words present.
6. Single-word block: in_last on the first word, value 0x1234 -> out_seq[0] = 0x1234, remaining slots PAD, out_count = 1.

Source files
------------

// File: rtl/bitonic_loader.sv
// Packs a serial valid/ready word stream into a DEPTH-wide block for the bitonic
// sorter, padding unfilled slots with a sentinel that sorts to the tail.

module bitonic_loader_slot #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] PAD   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || i_clr) r_q <= PAD;
    else if (i_we)    r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module bitonic_loader #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int DIR   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_seq [DEPTH-1:0],
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   out_count
);
  localparam int               IDXW     = $clog2(DEPTH);
  localparam int               CW       = IDXW + 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(DEPTH - 1);
  // Ascending sort pushes all-ones to the tail; descending pushes all-zeros.
  localparam logic [WIDTH-1:0] PAD      = (DIR != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic {S_FILL, S_ISSUE} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDXW-1:0]  r_idx, w_idx_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic             w_accept;
  logic             w_clr;
  logic [WIDTH-1:0] w_buf [DEPTH-1:0];

  logic [WIDTH-1:0] r_out_seq [DEPTH-1:0];
  logic             r_out_valid;
  logic [CW-1:0]    r_out_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_count_nxt = r_count;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      S_FILL: begin
        in_ready = !rst;
        w_accept = in_valid && !rst;
        if (w_accept) begin
          w_idx_nxt = r_idx + IDXW'(1);
          // Explicit last-slot compare: idx wraps to 0 on a full block.
          if (in_last || (r_idx == LAST_IDX)) begin
            w_count_nxt = CW'(r_idx) + CW'(1);
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_clr       = 1'b1;
        w_idx_nxt   = '0;
        w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    bitonic_loader_slot #(.WIDTH(WIDTH), .PAD(PAD)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .i_clr(w_clr),
      .i_we (w_accept && (r_idx == IDXW'(k))),
      .i_d  (in_data),
      .o_q  (w_buf[k])
    );
  end

  // Outputs are zero whenever not valid; the sorter consumes them unqualified.
  always_ff @(posedge clk) begin
    if (rst || (r_state != S_ISSUE)) begin
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      for (int k = 0; k < DEPTH; k++) r_out_seq[k] <= '0;
    end else begin
      r_out_valid <= 1'b1;
      r_out_count <= r_count;
      for (int k = 0; k < DEPTH; k++) r_out_seq[k] <= w_buf[k];
    end
  end

  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign out_seq   = r_out_seq;
endmodule

// File: tb/tb_bitonic_loader.sv
// Self-checking bench: two loaders (ascending and descending pad) share one random
// stream; a queue-based block model predicts every output cycle.

module tb_bitonic_loader;
  localparam int DEPTH = 8;
  localparam int W     = 32;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         rdy1, rdy0, v1, v0;
  logic [3:0]   c1, c0;
  logic [W-1:0] s1 [DEPTH-1:0];
  logic [W-1:0] s0 [DEPTH-1:0];

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bitonic_loader #(.DEPTH(DEPTH), .WIDTH(W), .DIR(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy1), .out_seq(s1), .out_valid(v1), .out_count(c1));

  bitonic_loader #(.DEPTH(DEPTH), .WIDTH(W), .DIR(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy0), .out_seq(s0), .out_valid(v0), .out_count(c0));

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Behavioural model: words collect in a queue; a finished block is shown one cycle later.
  logic [W-1:0] q[$];
  logic [W-1:0] m_blk [DEPTH];
  logic [W-1:0] e_blk [DEPTH];
  int           m_n = 0, e_c = 0;
  bit           m_issue = 0, e_v = 0, started = 0;
  int           cyc = 0;

  always @(posedge clk) begin
    started = 1;
    cyc++;
    if (rst) begin
      q.delete(); m_issue = 0; e_v = 0; e_c = 0;
    end else if (m_issue) begin
      e_v = 1; e_c = m_n; e_blk = m_blk; m_issue = 0;
    end else begin
      e_v = 0; e_c = 0;
      if (in_valid) begin
        q.push_back(in_data);
        if (in_last || q.size() == DEPTH) begin
          m_n = q.size();
          for (int k = 0; k < DEPTH; k++) m_blk[k] = (k < m_n) ? q[k] : '0;
          q.delete();
          m_issue = 1;
        end
      end
    end
  end

  function automatic logic [W-1:0] exp_word(int k, bit dir);
    if (!e_v)     return '0;
    if (k < e_c)  return e_blk[k];
    return dir ? {W{1'b1}} : {W{1'b0}};
  endfunction

  // Pulse capture for the directed literal checks.
  int           npulse = 0, last_cyc = 0, prev_cyc = 0, rdy_low = 0;
  logic [W-1:0] cap1 [DEPTH-1:0];
  logic [W-1:0] cap0 [DEPTH-1:0];
  logic [3:0]   capc;

  always @(negedge clk) begin
    if (started) begin
      bit m1, m0;
      int b1, b0;
      chk("in_ready_dir1", rdy1, !rst && !m_issue);
      chk("in_ready_dir0", rdy0, !rst && !m_issue);
      chk("out_valid_dir1", v1, e_v);
      chk("out_valid_dir0", v0, e_v);
      chk("out_count_dir1", c1, e_c);
      chk("out_count_dir0", c0, e_c);
      m1 = 0; m0 = 0; b1 = 0; b0 = 0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (s1[k] !== exp_word(k, 1)) begin m1 = 1; b1 = k; end
        if (s0[k] !== exp_word(k, 0)) begin m0 = 1; b0 = k; end
      end
      checks += 2;
      if (m1) begin errors++; $display("FAIL seq_dir1 slot %0d: got %h expected %h", b1, s1[b1], exp_word(b1, 1)); end
      if (m0) begin errors++; $display("FAIL seq_dir0 slot %0d: got %h expected %h", b0, s0[b0], exp_word(b0, 0)); end
      if (v1) begin
        npulse++; prev_cyc = last_cyc; last_cyc = cyc;
        cap1 = s1; cap0 = s0; capc = c1;
      end
      if (!rdy1 && !rst) rdy_low++;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic l);
    int  g;
    bit  acc;
    in_valid = 1'b1; in_data = d; in_last = l; g = 0; acc = 0;
    do begin
      @(negedge clk); acc = rdy1;
      @(posedge clk); #1;
      g++;
    end while (!acc && g < 50);
    if (!acc) chk("send_timeout", 0, 1);
    in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_data = $urandom; in_last = 1'($urandom);
      @(posedge clk); #1;
    end
    in_last = 1'b0;
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0; in_last = 1'b0; rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rl, len;
    logic l;

    // Reset state
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("reset_ready", rdy1, 0);
    chk("reset_valid", v1, 0);
    chk("reset_count", c1, 0);
    chk("reset_seq0", s1[0], 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", rdy1, 1);
    @(posedge clk); #1;

    // Full block, descending values
    base = npulse; rl = rdy_low;
    for (int i = 8; i >= 1; i--) send(i, i == 1);
    idle(3);
    chk("t1_pulses", npulse - base, 1);
    chk("t1_count", capc, 8);
    chk("t1_slot0", cap1[0], 8);
    chk("t1_slot7", cap1[7], 1);
    chk("t1_stall_cycles", rdy_low - rl, 1);

    // Short block, both pad polarities
    send(5, 0); send(9, 0); send(2, 1);
    idle(3);
    chk("t2_count", capc, 3);
    chk("t2_slot1", cap1[1], 9);
    chk("t2_slot2", cap1[2], 2);
    chk("t2_pad_asc", cap1[3], 32'hFFFF_FFFF);
    chk("t2_pad_asc7", cap1[7], 32'hFFFF_FFFF);
    chk("t2_pad_desc", cap0[3], 0);
    chk("t2_desc_slot0", cap0[0], 5);

    // Back-to-back full blocks
    base = npulse;
    for (int i = 0; i < 16; i++) send(100 + i, (i % 8) == 7);
    idle(3);
    chk("t3_pulses", npulse - base, 2);
    chk("t3_spacing", last_cyc - prev_cyc, 9);
    chk("t3_blk2_slot0", cap1[0], 108);
    chk("t3_blk2_slot7", cap1[7], 115);

    // Gapped input
    for (int i = 0; i < 4; i++) begin
      send(32'hC0 + i, i == 3);
      idle($urandom_range(0, 3));
    end
    idle(3);
    chk("t4_count", capc, 4);
    chk("t4_slot0", cap1[0], 32'hC0);
    chk("t4_slot3", cap1[3], 32'hC3);

    // Reset mid-fill discards partial block
    base = npulse;
    send(32'hA1, 0); send(32'hA2, 0); send(32'hA3, 0);
    do_reset(1);
    send(32'hB1, 0); send(32'hB2, 1);
    idle(3);
    chk("t5_pulses", npulse - base, 1);
    chk("t5_count", capc, 2);
    chk("t5_slot0", cap1[0], 32'hB1);
    chk("t5_slot1", cap1[1], 32'hB2);
    chk("t5_slot2_pad", cap1[2], 32'hFFFF_FFFF);

    // Reset during the issue cycle suppresses the pulse
    base = npulse;
    send(32'hDD, 1);
    do_reset(1);
    idle(3);
    chk("issue_reset_pulses", npulse - base, 0);

    // Single-word block
    send(32'h1234, 1);
    idle(3);
    chk("t6_count", capc, 1);
    chk("t6_slot0", cap1[0], 32'h1234);
    chk("t6_slot1_pad", cap1[1], 32'hFFFF_FFFF);
    chk("t6_desc_pad", cap0[7], 0);

    // Random blocks, gaps and occasional resets against the model
    for (int b = 0; b < 60; b++) begin
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) begin
        l = (i == len - 1) ? ((len == DEPTH) ? 1'($urandom) : 1'b1) : 1'b0;
        send($urandom, l);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 2));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
